// File: rtl/ft60x_245fifo_slave.sv
// FT600/FT601 245-synchronous-FIFO slave: the chip side of the USB FIFO bus,
// with FWFT buffers towards the host (AXI-Stream) in both directions.
module ft60x_245fifo_slave #(
   parameter int FIFO_BUS_WIDTH = 2,
   parameter int BUF_DEPTH      = 16
) (
   input  logic                          usb_clk,
   input  logic                          rstn_usbclk,
   output logic                          usb_txe_n,
   output logic                          usb_rxf_n,
   input  logic                          usb_wr_n,
   input  logic                          usb_rd_n,
   input  logic                          usb_oe_n,
   input  logic [FIFO_BUS_WIDTH-1:0]     usb_be_i,
   output logic [FIFO_BUS_WIDTH-1:0]     usb_be_o,
   output logic                          usb_be_t,
   input  logic [FIFO_BUS_WIDTH*8-1:0]   usb_data_i,
   output logic [FIFO_BUS_WIDTH*8-1:0]   usb_data_o,
   output logic                          usb_data_t,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic [FIFO_BUS_WIDTH*8-1:0]   s_axis_tdata,
   input  logic [FIFO_BUS_WIDTH-1:0]     s_axis_tkeep,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [FIFO_BUS_WIDTH*8-1:0]   m_axis_tdata,
   output logic [FIFO_BUS_WIDTH-1:0]     m_axis_tkeep,
   output logic [$clog2(BUF_DEPTH):0]    rd_level,
   output logic [$clog2(BUF_DEPTH):0]    wr_level,
   output logic                          err_underflow,
   output logic                          err_overflow,
   output logic                          err_conflict
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = FIFO_BUS_WIDTH * 8;
   localparam int EW = DW + FIFO_BUS_WIDTH;
   localparam logic [LW-1:0] FULL_LVL = LW'(BUF_DEPTH);

   logic [EW-1:0] rd_mem [BUF_DEPTH];
   logic [EW-1:0] wr_mem [BUF_DEPTH];
   logic [LW-1:0] rd_wptr, rd_rptr, wr_wptr, wr_rptr;
   logic [LW-1:0] rd_level_nxt, wr_level_nxt;
   logic [EW-1:0] rd_head, wr_head;
   logic          rd_push, rd_pop, wr_push, wr_pop, wr_full;
   logic          bus_read, bus_write;

   // RDBUF: host -> master
   assign s_axis_tready = rstn_usbclk & (rd_level != FULL_LVL);
   assign rd_push       = s_axis_tvalid & s_axis_tready;
   assign bus_read      = ~usb_oe_n & ~usb_rd_n;
   assign rd_pop        = bus_read & (rd_level != '0);
   assign rd_head       = rd_mem[rd_rptr[AW-1:0]];

   // WRBUF: master -> host; a write strobe while the chip owns the bus is a conflict
   assign bus_write = ~usb_wr_n;
   assign wr_full   = (wr_wptr[AW] != wr_rptr[AW]) && (wr_wptr[AW-1:0] == wr_rptr[AW-1:0]);
   assign wr_push   = bus_write & usb_oe_n & ~wr_full;
   assign m_axis_tvalid = (wr_level != '0);
   assign wr_pop    = m_axis_tvalid & m_axis_tready;
   assign wr_head   = wr_mem[wr_rptr[AW-1:0]];
   assign m_axis_tdata = wr_head[DW-1:0];
   assign m_axis_tkeep = wr_head[EW-1:DW];

   assign usb_data_t = usb_oe_n;
   assign usb_be_t   = usb_oe_n;

   always_comb begin
      usb_data_o = '0;
      usb_be_o   = '0;
      if (!usb_oe_n && rd_level != '0) begin
         usb_data_o = rd_head[DW-1:0];
         usb_be_o   = rd_head[EW-1:DW];
      end
   end

   always_comb begin
      rd_level_nxt = rd_level;
      if (rd_push && !rd_pop)
         rd_level_nxt = rd_level + LW'(1);
      else if (!rd_push && rd_pop)
         rd_level_nxt = rd_level - LW'(1);
      wr_level_nxt = wr_level;
      if (wr_push && !wr_pop)
         wr_level_nxt = wr_level + LW'(1);
      else if (!wr_push && wr_pop)
         wr_level_nxt = wr_level - LW'(1);
   end

   // Storage carries no reset; pointers alone define what is valid
   always_ff @(posedge usb_clk) begin
      if (rd_push)
         rd_mem[rd_wptr[AW-1:0]] <= {s_axis_tkeep, s_axis_tdata};
      if (wr_push)
         wr_mem[wr_wptr[AW-1:0]] <= {usb_be_i, usb_data_i};
   end

   always_ff @(posedge usb_clk or negedge rstn_usbclk) begin
      if (!rstn_usbclk) begin
         rd_wptr       <= '0;
         rd_rptr       <= '0;
         wr_wptr       <= '0;
         wr_rptr       <= '0;
         rd_level      <= '0;
         wr_level      <= '0;
         usb_rxf_n     <= 1'b1;
         usb_txe_n     <= 1'b1;
         err_underflow <= 1'b0;
         err_overflow  <= 1'b0;
         err_conflict  <= 1'b0;
      end else begin
         if (rd_push) rd_wptr <= rd_wptr + LW'(1);
         if (rd_pop)  rd_rptr <= rd_rptr + LW'(1);
         if (wr_push) wr_wptr <= wr_wptr + LW'(1);
         if (wr_pop)  wr_rptr <= wr_rptr + LW'(1);
         rd_level  <= rd_level_nxt;
         wr_level  <= wr_level_nxt;
         usb_rxf_n <= (rd_level_nxt == '0);
         usb_txe_n <= (wr_level_nxt == FULL_LVL);
         if (bus_read && rd_level == '0)        err_underflow <= 1'b1;
         if (bus_write && usb_oe_n && wr_full)  err_overflow  <= 1'b1;
         if (bus_write && !usb_oe_n)            err_conflict  <= 1'b1;
      end
   end

endmodule
